// File: rtl/bird_datapath_if.sv
// Pixel-plot bus from the bird datapath (master) to the VGA adapter (slave).
interface bird_datapath_if;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;

  modport master (output x, y, colour, plot);
  modport slave  (input  x, y, colour, plot);
endinterface

// File: rtl/bird_datapath.sv
// Bird sprite datapath: on each frame tick it erases the sprite, moves it by the
// motion code latched from the control FSM, redraws it and reports flag/touched.
module bird_datapath #(
  parameter logic [7:0] X_POS       = 8'd20,
  parameter logic [6:0] Y_START     = 7'd60,
  parameter int         BIRD_SIZE   = 4,
  parameter logic [6:0] RISE_STEP   = 7'd2,
  parameter logic [6:0] FALL_STEP   = 7'd1,
  parameter logic [6:0] CEILING     = 7'd8,
  parameter logic [7:0] GROUND      = 8'd112,
  parameter logic [2:0] BG_COLOUR   = 3'b011,
  parameter logic [2:0] BIRD_COLOUR = 3'b110,
  parameter logic [2:0] DEAD_COLOUR = 3'b100
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [2:0]      state_i,
  input  logic            press_key_i,
  input  logic            pipe_hit_i,
  input  logic            frame_tick_i,
  output logic            flag_o,
  output logic            touched_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [6:0]      bird_y_o,
  bird_datapath_if.master vga
);
  localparam int N2 = BIRD_SIZE * BIRD_SIZE;
  localparam int SW = $clog2(BIRD_SIZE);
  localparam int CW = $clog2(N2);
  localparam logic [CW-1:0] LAST       = CW'(N2 - 1);
  localparam logic [7:0]    SIZE8      = 8'(BIRD_SIZE);
  localparam logic [7:0]    GROUND_TOP = GROUND - SIZE8;
  localparam logic [7:0]    RISE_LIMIT = {1'b0, CEILING} + {1'b0, RISE_STEP};

  typedef enum logic [2:0] {
    MOT_STOP  = 3'b001,
    MOT_START = 3'b010,
    MOT_FALL  = 3'b011,
    MOT_RAISE = 3'b110
  } motion_e;

  typedef enum logic [2:0] {S_IDLE, S_ERASE, S_MOVE, S_DRAW, S_DONE} seq_e;

  seq_e          seq_q, seq_d;
  motion_e       motion_q, motion_d;
  logic [CW-1:0] cnt_q, cnt_d, pixCnt;
  logic [6:0]    birdY_q, birdY_d, y_q, y_d, moveY, pixBase;
  logic [7:0]    x_q, x_d, fallSum;
  logic [2:0]    colour_q, colour_d, drawColour;
  logic          hit_q, hit_d, touched_q, touched_d, flag_q, flag_d;
  logic          done_q, done_d, plot_q, plot_d, moveTouched;

  // Position the sprite would take if this frame's MOVE happened now.
  always_comb begin
    fallSum    = {1'b0, birdY_q} + {1'b0, FALL_STEP};
    drawColour = (motion_q == MOT_STOP) ? DEAD_COLOUR : BIRD_COLOUR;
    moveY      = birdY_q;
    case (motion_q)
      MOT_START: moveY = Y_START;
      MOT_RAISE: moveY = ({1'b0, birdY_q} >= RISE_LIMIT) ? birdY_q - RISE_STEP : CEILING;
      MOT_FALL:  moveY = 7'((fallSum < GROUND_TOP) ? fallSum : GROUND_TOP);
      default:   moveY = birdY_q;
    endcase
    moveTouched = touched_q | hit_q | pipe_hit_i | (({1'b0, moveY} + SIZE8) >= GROUND);
  end

  always_comb begin
    seq_d     = seq_q;
    cnt_d     = cnt_q;
    motion_d  = motion_q;
    hit_d     = hit_q | pipe_hit_i;
    birdY_d   = birdY_q;
    touched_d = touched_q;
    flag_d    = flag_q;
    done_d    = 1'b0;
    plot_d    = 1'b0;
    colour_d  = colour_q;
    x_d       = x_q;
    y_d       = y_q;
    pixCnt    = cnt_q + CW'(1);
    pixBase   = birdY_q;

    // DRAW code holds the previous motion; unknown codes behave like STOP.
    case (state_i)
      3'b010:  motion_d = MOT_START;
      3'b110:  motion_d = MOT_RAISE;
      3'b011:  motion_d = MOT_FALL;
      3'b111:  motion_d = motion_q;
      default: motion_d = MOT_STOP;
    endcase

    case (seq_q)
      S_IDLE: begin
        if (frame_tick_i) begin
          seq_d    = S_ERASE;
          cnt_d    = '0;
          pixCnt   = '0;
          plot_d   = 1'b1;
          colour_d = BG_COLOUR;
        end
      end
      S_ERASE: begin
        if (cnt_q == LAST) begin
          seq_d = S_MOVE;
        end else begin
          cnt_d    = pixCnt;
          plot_d   = 1'b1;
          colour_d = BG_COLOUR;
        end
      end
      S_MOVE: begin
        birdY_d = moveY;
        if (motion_q == MOT_START) begin
          touched_d = 1'b0;
          hit_d     = 1'b0;
        end else begin
          touched_d = moveTouched;
        end
        seq_d    = S_DRAW;
        cnt_d    = '0;
        pixCnt   = '0;
        pixBase  = moveY;
        plot_d   = 1'b1;
        colour_d = drawColour;
      end
      S_DRAW: begin
        if (cnt_q == LAST) begin
          seq_d  = S_DONE;
          done_d = 1'b1;
          flag_d = press_key_i & (birdY_q > CEILING) & ~touched_q;
        end else begin
          cnt_d    = pixCnt;
          plot_d   = 1'b1;
          colour_d = drawColour;
        end
      end
      default: seq_d = S_IDLE;
    endcase

    if (plot_d) begin
      x_d = X_POS + {{(8 - SW){1'b0}}, pixCnt[SW-1:0]};
      y_d = pixBase + {{(7 - (CW - SW)){1'b0}}, pixCnt[CW-1:SW]};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      seq_q     <= S_IDLE;
      cnt_q     <= '0;
      motion_q  <= MOT_START;
      hit_q     <= 1'b0;
      birdY_q   <= Y_START;
      touched_q <= 1'b0;
      flag_q    <= 1'b0;
      done_q    <= 1'b0;
      plot_q    <= 1'b0;
      x_q       <= X_POS;
      y_q       <= Y_START;
      colour_q  <= '0;
    end else begin
      seq_q     <= seq_d;
      cnt_q     <= cnt_d;
      motion_q  <= motion_d;
      hit_q     <= hit_d;
      birdY_q   <= birdY_d;
      touched_q <= touched_d;
      flag_q    <= flag_d;
      done_q    <= done_d;
      plot_q    <= plot_d;
      x_q       <= x_d;
      y_q       <= y_d;
      colour_q  <= colour_d;
    end
  end

  assign vga.x      = x_q;
  assign vga.y      = y_q;
  assign vga.colour = colour_q;
  assign vga.plot   = plot_q;
  assign flag_o     = flag_q;
  assign touched_o  = touched_q;
  assign done_o     = done_q;
  assign busy_o     = (seq_q != S_IDLE);
  assign bird_y_o   = birdY_q;
endmodule
